// File: rtl/seg_scan_driver.sv
// Time-multiplexes a DIGITS x 7-segment glyph frame onto a common-select display,
// reloading a shadow frame only at frame wrap. Optional dead time via SEG_BLANK_EN.
module seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 8,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS*7-1:0]   seg_data,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV + BLANK_CYC) + 1;
  localparam int IW = $clog2(DIGITS) + 1;

  // XOR masks double as the inactive output levels.
  localparam logic [6:0]        SEG_MASK = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_MASK = DIG_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

`ifdef SEG_BLANK_EN
  typedef enum logic [1:0] {S_LOAD, S_SHOW, S_BLANK} state_t;
`else
  typedef enum logic [1:0] {S_LOAD, S_SHOW} state_t;
`endif

  state_t                state, state_n;
  logic [DIGITS*7-1:0]   shadow, shadow_n;
  logic [IW-1:0]         idx, idx_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [6:0]            seg_n;
  logic [DIGITS-1:0]     dig_n;
  logic                  fd_n;
  logic                  adv;

  function automatic logic [6:0] glyph(input logic [DIGITS*7-1:0] frame, input logic [IW-1:0] i);
    return 7'(frame >> (7 * (DIGITS - 1 - int'(i))));
  endfunction

  function automatic logic [DIGITS-1:0] onehot(input logic [IW-1:0] i);
    return DIGITS'(1) << i;
  endfunction

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    idx_n    = idx;
    cnt_n    = cnt;
    seg_n    = seg;
    dig_n    = dig_sel;
    fd_n     = 1'b0;
    adv      = 1'b0;
    case (state)
      S_LOAD: begin
        shadow_n = seg_data;
        idx_n    = '0;
        cnt_n    = '0;
        state_n  = S_SHOW;
        seg_n    = glyph(seg_data, '0) ^ SEG_MASK;
        dig_n    = onehot('0) ^ DIG_MASK;
      end
      S_SHOW: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          cnt_n = '0;
`ifdef SEG_BLANK_EN
          state_n = S_BLANK;
          seg_n   = SEG_MASK;
          dig_n   = DIG_MASK;
`else
          adv = 1'b1;
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef SEG_BLANK_EN
      S_BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_SHOW;
          adv     = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      default: state_n = S_LOAD;
    endcase

    // Leaving the last digit's dwell wraps and samples a fresh frame on the same edge.
    if (adv) begin
      if (idx == IW'(DIGITS - 1)) begin
        idx_n    = '0;
        shadow_n = seg_data;
        fd_n     = 1'b1;
        seg_n    = glyph(seg_data, '0) ^ SEG_MASK;
        dig_n    = onehot('0) ^ DIG_MASK;
      end else begin
        idx_n = idx + IW'(1);
        seg_n = glyph(shadow, idx + IW'(1)) ^ SEG_MASK;
        dig_n = onehot(idx + IW'(1)) ^ DIG_MASK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      shadow     <= '0;
      idx        <= '0;
      cnt        <= '0;
      seg        <= SEG_MASK;
      dig_sel    <= DIG_MASK;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      seg        <= seg_n;
      dig_sel    <= dig_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a timeline model (position in frame
// derived from cycles since load); checks both output polarities.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int ND = 4;
`ifdef SEG_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif
  localparam int P  = SD + BL;
  localparam int FL = ND * P;

  logic        clk;
  logic        rst_n;
  logic [27:0] seg_data;
  logic [6:0]  seg, seg_i;
  logic [3:0]  dig_sel, dig_sel_i;
  logic        frame_done, frame_done_i;

  seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(2), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .seg_data(seg_data),
    .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(2), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .seg_data(seg_data),
    .seg(seg_i), .dig_sel(dig_sel_i), .frame_done(frame_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: cycles since the load edge and the frame captured for display.
  bit          loaded = 1'b0;
  int          t = 0;
  logic [27:0] frame = '0;
  bit          fd_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [6:0] eseg;
    logic [3:0] edig;
    int slot, pos;
    @(posedge clk);
    if (!rst_n) begin
      loaded = 1'b0;
      fd_exp = 1'b0;
    end else if (!loaded) begin
      loaded = 1'b1;
      t      = 0;
      frame  = seg_data;
      fd_exp = 1'b0;
    end else begin
      t++;
      fd_exp = (t % FL == 0);
      if (fd_exp) frame = seg_data;
    end
    @(negedge clk);
    eseg = 7'h00;
    edig = 4'h0;
    if (loaded) begin
      slot = (t % FL) / P;
      pos  = t % P;
      if (pos < SD) begin
        eseg = frame[(ND-1-slot)*7 +: 7];
        edig = 4'(1 << slot);
      end
    end
    chk("seg",          32'(seg),          32'(eseg));
    chk("dig_sel",      32'(dig_sel),      32'(edig));
    chk("frame_done",   32'(frame_done),   32'(fd_exp));
    chk("seg_inv",      32'(seg_i),        32'(eseg ^ 7'h7F));
    chk("dig_sel_inv",  32'(dig_sel_i),    32'(edig ^ 4'hF));
    chk("frame_done_i", 32'(frame_done_i), 32'(fd_exp));
  endtask

  initial begin
    rst_n    = 1'b0;
    seg_data = 28'hFFFFFFF;
    repeat (3) step();

    seg_data = {7'h06, 7'h5B, 7'h4F, 7'h66};
    rst_n    = 1'b1;
    repeat (FL + P + 1) step();

    // Mid-frame data change must wait for the next reload.
    seg_data = {4{7'h7F}};
    repeat (2 * FL) step();

    seg_data = {7'h06, 7'h5B, 7'h4F, 7'h66};
    for (int i = 0; i < 4 * FL; i++) begin
      if (loaded && ((t % FL) / P == 2) && (t % P < SD)) break;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (FL + 3) step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) seg_data = 28'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
